axi4_cdc_fifo6_wr_arb: RTL

Write-domain arbiter that shares the single write port of a 6-bit CDC FIFO between four requesters. Each requester offers 4-bit payload words in bursts. The block grants the port round-robin, holds the grant for a burst, and tags every word with the 2-bit requester ID, so the read domain can demultiplex the stream. It sits in the `wr_clk_i` domain directly in front of the FIFO's `wr_push_i`/`wr_data_i`/`wr_full_o` port and registers its output.

---
 rtl/axi4_cdc_fifo6_wr_arb.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/axi4_cdc_fifo6_wr_arb.sv
// Write-domain round-robin arbiter feeding the write port of a 6-bit CDC FIFO.
// Words are tagged with the 2-bit owner ID and leave through one output register.

module axi4_cdc_fifo6_wr_arb_lane #(
    parameter int PAY_W = 4
) (
    input  logic             valid,
    input  logic             mask,
    input  logic             last,
    input  logic             owner,
    input  logic             accept,
    input  logic [PAY_W-1:0] data,
    output logic             elig,
    output logic             ready,
    output logic             xfer,
    output logic             xlast,
    output logic [PAY_W-1:0] data_sel
);
    assign elig     = valid & mask;
    assign ready    = owner & accept;
    assign xfer     = ready & valid;
    assign xlast    = xfer & last;
    assign data_sel = owner ? data : '0;
endmodule

module axi4_cdc_fifo6_wr_arb #(
    parameter int BURST_MAX = 4
) (
    input  logic        wr_clk_i,
    input  logic        wr_rst_i,
    input  logic [3:0]  req_mask_i,
    input  logic [3:0]  req_valid_i,
    input  logic [15:0] req_data_i,
    input  logic [3:0]  req_last_i,
    output logic [3:0]  req_ready_o,
    input  logic        fifo_full_i,
    output logic        fifo_push_o,
    output logic [5:0]  fifo_data_o,
    output logic [3:0]  grant_o,
    output logic        busy_o
);
    localparam int NUM_REQ = 4;
    localparam int PAY_W   = 4;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  beat_q, beat_d;
    logic        out_valid_q, out_valid_d;
    logic [5:0]  out_data_q, out_data_d;

    logic                              accept;
    logic [NUM_REQ-1:0]                own_vec, elig, ready, xfer_v, xlast_v;
    logic [NUM_REQ-1:0][PAY_W-1:0]     data_sel;
    logic [PAY_W-1:0]                  payload;
    logic                              xfer, xlast, burst_end, leave;
    logic [1:0]                        sel, idx;
    logic                              sel_ok;

    always_comb begin
        for (int n = 0; n < NUM_REQ; n++)
            own_vec[n] = (state_q == GRANT) && (owner_q == 2'(n));
    end

    // Ready may only fall combinationally on a full FIFO with the register occupied.
    assign accept = ~out_valid_q | ~fifo_full_i;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        axi4_cdc_fifo6_wr_arb_lane #(.PAY_W(PAY_W)) u_lane (
            .valid    (req_valid_i[g]),
            .mask     (req_mask_i[g]),
            .last     (req_last_i[g]),
            .owner    (own_vec[g]),
            .accept   (accept),
            .data     (req_data_i[PAY_W*g +: PAY_W]),
            .elig     (elig[g]),
            .ready    (ready[g]),
            .xfer     (xfer_v[g]),
            .xlast    (xlast_v[g]),
            .data_sel (data_sel[g])
        );
    end

    always_comb begin
        payload = '0;
        for (int n = 0; n < NUM_REQ; n++)
            payload = payload | data_sel[n];
    end

    assign xfer      = |xfer_v;
    assign xlast     = |xlast_v;
    assign burst_end = xfer & (xlast | (beat_q == 4'(BURST_MAX - 1)));
    assign leave     = out_valid_q & ~fifo_full_i;

    // First eligible requester at or after rr_ptr_q, wrapping modulo 4.
    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = rr_ptr_q + 2'(i);
            if (!sel_ok && elig[idx]) begin
                sel    = idx;
                sel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (leave)
            out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_ok) begin
                    state_d = GRANT;
                    owner_d = sel;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    out_data_d  = {owner_q, payload};
                    out_valid_d = 1'b1;
                    beat_d      = beat_q + 4'd1;
                    if (burst_end) begin
                        state_d  = IDLE;
                        rr_ptr_d = owner_q + 2'd1;
                        beat_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk_i or posedge wr_rst_i) begin
        if (wr_rst_i) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign req_ready_o = ready;
    assign fifo_push_o = out_valid_q;
    assign fifo_data_o = out_data_q;
    assign grant_o     = own_vec;
    assign busy_o      = (state_q == GRANT) | out_valid_q;
endmodule
